// File: rtl/spi_pkg.sv
// Shared SPI master definitions: command codes, expected device ID, FSM state encoding.
// Used by spi_master, whose optional ID check is enabled by SPI_MASTER_ID_CHECK_EN.
package spi_pkg;

  localparam logic [7:0] CMD_READ_ID = 8'h1D;
  localparam logic [7:0] CMD_READ    = 8'hEA;
  localparam logic [7:0] CMD_WRITE   = 8'hAD;
  localparam logic [7:0] DEVICE_ID   = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_DATA,
    ST_CS_HOLD,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    KIND_OTHER,
    KIND_READ_ID,
    KIND_READ,
    KIND_WRITE
  } cmd_kind_t;

  function automatic cmd_kind_t decode_cmd(input logic [7:0] c);
    cmd_kind_t k;
    case (c)
      CMD_READ_ID: k = KIND_READ_ID;
      CMD_READ:    k = KIND_READ;
      CMD_WRITE:   k = KIND_WRITE;
      default:     k = KIND_OTHER;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer and SPI clock level for spi_master.
// tick marks the last clk cycle of each half-period; sck toggles on tick only when toggle is set.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic toggle,
  output logic tick,
  output logic sck
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      // Reload on every half-period edge so each phase starts aligned.
      cnt <= '0;
      if (toggle) sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: 8-bit command then WIDTH-bit data phase, MSB first, one chip select.
// Define SPI_MASTER_ID_CHECK_EN to add the id_err output (READ_ID response check).
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       cmd,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             sck,
  output logic             _cs,
  output logic             mosi,
  input  logic             miso,
  output logic [2:0]       state
`ifdef SPI_MASTER_ID_CHECK_EN
  ,
  output logic             id_err
`endif
);

  localparam int TW = 8 + WIDTH;
  localparam logic [4:0] LAST_CMD_BIT  = 5'd7;
  localparam logic [4:0] LAST_DATA_BIT = 5'(WIDTH - 1);

  state_t        state_q, state_d;
  logic          tick, fall, run, toggle, accept, phase_last;
  logic [4:0]    bit_cnt;
  logic [TW-1:0] tx_sr;

  assign state  = state_q;
  assign accept = (state_q == ST_IDLE) && start;
  // A bit ends on the half-period tick that takes sck from high to low.
  assign fall   = tick && sck && ((state_q == ST_CMD) || (state_q == ST_DATA));
  assign phase_last = (state_q == ST_CMD) ? (bit_cnt == LAST_CMD_BIT)
                                          : (bit_cnt == LAST_DATA_BIT);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .toggle (toggle),
    .tick   (tick),
    .sck    (sck)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    _cs     = 1'b0;
    run     = 1'b1;
    toggle  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        _cs  = 1'b1;
        run  = 1'b0;
        if (start) state_d = ST_CS_SETUP;
      end
      ST_CS_SETUP: begin
        if (tick) state_d = ST_CMD;
      end
      ST_CMD: begin
        toggle = 1'b1;
        if (fall && phase_last) state_d = ST_DATA;
      end
      ST_DATA: begin
        toggle = 1'b1;
        if (fall && phase_last) state_d = ST_CS_HOLD;
      end
      ST_CS_HOLD: begin
        if (tick) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        _cs     = 1'b1;
        run     = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        _cs     = 1'b1;
        run     = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr   <= '0;
      mosi    <= 1'b0;
      bit_cnt <= '0;
      rdata   <= '0;
    end else if (accept) begin
      // Non-WRITE commands clock zeros out during the data phase.
      tx_sr   <= {cmd, (decode_cmd(cmd) == KIND_WRITE) ? wdata : WIDTH'(0)};
      mosi    <= cmd[7];
      bit_cnt <= '0;
    end else if (fall) begin
      tx_sr   <= {tx_sr[TW-2:0], 1'b0};
      mosi    <= tx_sr[TW-2];
      bit_cnt <= phase_last ? 5'd0 : bit_cnt + 5'd1;
      if (state_q == ST_DATA) rdata <= {rdata[WIDTH-2:0], miso};
    end
  end

`ifdef SPI_MASTER_ID_CHECK_EN
  logic is_read_id_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_err       <= 1'b0;
      is_read_id_q <= 1'b0;
    end else if (accept) begin
      id_err       <= 1'b0;
      is_read_id_q <= (decode_cmd(cmd) == KIND_READ_ID);
    end else if ((state_q == ST_DONE) && is_read_id_q && (rdata != WIDTH'(DEVICE_ID))) begin
      id_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (WIDTH=8, CLK_DIV=4) with a mode-0 slave model.
// Checks id_err as well when SPI_MASTER_ID_CHECK_EN is defined.
module tb_spi_master;
  import spi_pkg::*;

  localparam int WIDTH   = 8;
  localparam int CLK_DIV = 4;
  localparam int LAT     = 137;

  logic             clk, rst, start, miso;
  logic [7:0]       cmd;
  logic [WIDTH-1:0] wdata, rdata;
  logic             busy, done, sck, cs_n, mosi;
  logic [2:0]       state;
`ifdef SPI_MASTER_ID_CHECK_EN
  logic             id_err;
`endif

  spi_master #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cmd   (cmd),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .sck   (sck),
    ._cs   (cs_n),
    .mosi  (mosi),
    .miso  (miso),
    .state (state)
`ifdef SPI_MASTER_ID_CHECK_EN
    ,
    .id_err(id_err)
`endif
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model and bus monitors
  logic [7:0]  slave_resp = 8'h00;
  logic [15:0] mosi_cap = 16'h0;
  int          rise_cnt = 0;
  int          fall_cnt = 0;
  int          mosi_viol = 0;
  int          done_cnt = 0;
  logic        prev_mosi = 1'b0;

  always @(negedge cs_n) begin
    fall_cnt = 0;
    miso = 1'b0;
  end

  always @(negedge sck) begin
    #1;
    fall_cnt++;
    if (fall_cnt >= 8 && fall_cnt < 16) miso = slave_resp[15 - fall_cnt];
    else miso = 1'b0;
  end

  always @(posedge sck) begin
    mosi_cap = {mosi_cap[14:0], mosi};
    rise_cnt++;
  end

  always @(negedge clk) begin
    if (!rst && (mosi !== prev_mosi) && sck) mosi_viol++;
    prev_mosi = mosi;
    if (done) done_cnt++;
  end

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  wdata;
    logic [7:0]  resp;
    logic [7:0]  exp_rdata;
    logic [15:0] exp_mosi;
    logic        exp_id_err;
    logic        inject;
  } vec_t;

  vec_t vecs[7];

  // driver tasks (always entered at a negedge of clk)
  task automatic do_start(input logic [7:0] c, input logic [7:0] w, input logic [7:0] r);
    slave_resp = r;
    mosi_cap   = 16'h0;
    rise_cnt   = 0;
    start      = 1'b1;
    cmd        = c;
    wdata      = w;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
    cmd   = ~c;
    wdata = ~w;
    check("setup_busy", busy, 1);
    check("setup_cs", cs_n, 0);
    check("setup_sck", sck, 0);
    check("setup_mosi", mosi, c[7]);
`ifdef SPI_MASTER_ID_CHECK_EN
    check("id_err_cleared", id_err, 0);
`endif
  endtask

  task automatic wait_done(input logic inject, output int dcyc);
    int errs;
    errs = 0;
    dcyc = -1;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      if (cs_n !== 1'b0 || busy !== 1'b1) errs++;
      if (inject && i == 20) begin
        start = 1'b1;
        cmd   = 8'h55;
        wdata = 8'h0F;
      end
      if (inject && i == 21) start = 1'b0;
      @(negedge clk);
    end
    check("done_seen", done, 1);
    check("cs_busy_during_txn", errs, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int dcyc;
    do_start(v.cmd, v.wdata, v.resp);
    wait_done(v.inject, dcyc);
    check("latency", dcyc - start_cyc, LAT);
    check("done_cs_high", cs_n, 1);
    check("done_busy", busy, 1);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("idle_busy", busy, 0);
    check("rdata", rdata, v.exp_rdata);
    check("mosi_bits", mosi_cap, v.exp_mosi);
    check("sck_rises", rise_cnt, 16);
`ifdef SPI_MASTER_ID_CHECK_EN
    check("id_err", id_err, v.exp_id_err);
`endif
  endtask

  initial begin
    int done_before;
    vecs[0] = '{8'h1D, 8'h00, 8'h5A, 8'h5A, 16'h1D00, 1'b0, 1'b0};
    vecs[1] = '{8'hAD, 8'h3C, 8'h00, 8'h00, 16'hAD3C, 1'b0, 1'b0};
    vecs[2] = '{8'hEA, 8'hFF, 8'hC4, 8'hC4, 16'hEA00, 1'b0, 1'b0};
    vecs[3] = '{8'h1D, 8'h00, 8'hA5, 8'hA5, 16'h1D00, 1'b1, 1'b0};
    vecs[4] = '{8'h55, 8'h77, 8'h81, 8'h81, 16'h5500, 1'b0, 1'b0};
    vecs[5] = '{8'hAD, 8'hC3, 8'h96, 8'h96, 16'hADC3, 1'b0, 1'b1};
    vecs[6] = '{8'hEA, 8'h00, 8'hFF, 8'hFF, 16'hEA00, 1'b0, 1'b0};

    start = 1'b0;
    cmd   = 8'h00;
    wdata = 8'h00;
    miso  = 1'b0;
    rst   = 1'b1;
    #1;
    check("rst_cs", cs_n, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_state", state, ST_IDLE);
`ifdef SPI_MASTER_ID_CHECK_EN
    check("rst_id_err", id_err, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // back-to-back table: each start lands in the IDLE cycle after DONE
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // asynchronous abort during bit 5 of the command phase
    repeat (2) @(negedge clk);
    do_start(8'hAD, 8'h3C, 8'h00);
    for (int i = 0; i < 200 && rise_cnt < 6; i++) @(negedge clk);
    check("abort_at_bit5", rise_cnt, 6);
    check("abort_in_cmd", state, ST_CMD);
    check("abort_sck_high", sck, 1);
    done_before = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("abort_cs", cs_n, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    check("abort_mosi", mosi, 0);
    check("abort_done", done, 0);
    check("abort_state", state, ST_IDLE);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - done_before, 0);
    check("abort_idle_busy", busy, 0);
    run_vec(vecs[1]);
    run_vec(vecs[0]);

    check("mosi_stable_while_sck_high", mosi_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
